// File: rtl/vm_pkg.sv
// Shared item codes, widths and FSM state encodings for the vending
// dispense/hopper scheduler.
package vm_pkg;
  localparam int ITEM_W    = 2;
  localparam int NUM_ITEMS = 4;
  localparam int REL_W     = 3;

  typedef enum logic [ITEM_W-1:0] {
    WATER = 2'b00,
    TEA   = 2'b01,
    COKE  = 2'b10,
    JUICE = 2'b11
  } item_e;

  typedef enum logic {
    DSP_IDLE = 1'b0,
    DSP_RUN  = 1'b1
  } disp_state_e;

  typedef enum logic [1:0] {
    HOP_IDLE  = 2'd0,
    HOP_EJECT = 2'd1,
    HOP_GAP   = 2'd2
  } hop_state_e;
endpackage

// File: rtl/vm_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester
// at or after ptr_i, wrapping modulo N.
module vm_rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic          valid_o
);
  logic found;

  // Outer loop walks priority distance from ptr_i; inner loop keeps indices constant.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!found && req_i[j] && (((j - int'(ptr_i) + N) % N) == i)) begin
          gnt_o[j] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

  assign valid_o = |req_i;
endmodule

// File: rtl/vend_dispense_scheduler.sv
// Shares one dispense motor and one coin hopper between N_REQ front-ends:
// release slots, stock tracking, round-robin grants and mechanism timing.
module vend_dispense_scheduler
  import vm_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int DISP_CYCLES = 4,
  parameter int COIN_GAP    = 2,
  parameter int STOCK_W     = 4,
  parameter int STOCK_INIT  = 10,
  parameter int CHG_W       = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [REL_W*N_REQ-1:0]   item_rels,
  input  logic [N_REQ-1:0]         change_return,
  input  logic                     restock,
  output logic                     disp_start,
  output logic [ITEM_W-1:0]        disp_item,
  output logic                     disp_busy,
  output logic                     coin_eject,
  output logic [NUM_ITEMS-1:0]     sold_out,
  output logic [N_REQ-1:0]         rel_ack,
  output logic [N_REQ-1:0]         err
);
  localparam int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int DCNT_W = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;
  localparam int GCNT_W = (COIN_GAP > 1) ? $clog2(COIN_GAP) : 1;

  logic [N_REQ-1:0]     slot_full_q, slot_full_d;
  logic [ITEM_W-1:0]    slot_item_q [N_REQ];
  logic [ITEM_W-1:0]    slot_item_d [N_REQ];
  logic [STOCK_W-1:0]   stock_q [NUM_ITEMS];
  logic [STOCK_W-1:0]   stock_d [NUM_ITEMS];
  disp_state_e          dst_q, dst_d;
  logic [DCNT_W-1:0]    dcnt_q, dcnt_d;
  logic [PTR_W-1:0]     drr_q, drr_d, owner_q, owner_d, dsel;
  logic [ITEM_W-1:0]    ditem_q, ditem_d, gitem;
  logic                 start_q, start_d, busy_q, busy_d, can_grant;
  logic [N_REQ-1:0]     ack_q, ack_d, err_q, err_d, ovf, dgnt;
  logic                 dgnt_v;
  logic [NUM_ITEMS-1:0] sold_q, sold_d;

  hop_state_e           hst_q, hst_d;
  logic [GCNT_W-1:0]    gcnt_q, gcnt_d;
  logic [PTR_W-1:0]     hrr_q, hrr_d, hsel;
  logic [CHG_W-1:0]     owed_q [N_REQ];
  logic [CHG_W-1:0]     owed_d [N_REQ];
  logic [N_REQ-1:0]     owed_nz, hgnt, hdec;
  logic                 hgnt_v, coin_q, coin_d;

  vm_rr_arbiter #(.N(N_REQ), .PW(PTR_W)) u_disp_arb (
    .req_i(slot_full_q), .ptr_i(drr_q), .gnt_o(dgnt), .valid_o(dgnt_v)
  );

  vm_rr_arbiter #(.N(N_REQ), .PW(PTR_W)) u_hop_arb (
    .req_i(owed_nz), .ptr_i(hrr_q), .gnt_o(hgnt), .valid_o(hgnt_v)
  );

  always_comb begin
    dsel = '0;
    hsel = '0;
    for (int r = 0; r < N_REQ; r++) begin
      if (dgnt[r]) dsel = PTR_W'(r);
      if (hgnt[r]) hsel = PTR_W'(r);
      owed_nz[r] = |owed_q[r];
    end
  end

  // Dispense path; the last RUN cycle doubles as an IDLE so back-to-back grants lose no cycle.
  always_comb begin
    dst_d       = dst_q;
    dcnt_d      = dcnt_q;
    drr_d       = drr_q;
    owner_d     = owner_q;
    ditem_d     = ditem_q;
    slot_full_d = slot_full_q;
    slot_item_d = slot_item_q;
    stock_d     = stock_q;
    start_d     = 1'b0;
    busy_d      = busy_q;
    ack_d       = '0;
    err_d       = '0;
    gitem       = slot_item_q[dsel];
    can_grant   = (dst_q == DSP_IDLE) || (dcnt_q == '0);

    if (dst_q == DSP_RUN) begin
      if (dcnt_q == '0) begin
        ack_d[owner_q] = 1'b1;
        busy_d         = 1'b0;
        dst_d          = DSP_IDLE;
      end else begin
        dcnt_d = dcnt_q - 1'b1;
      end
    end

    if (can_grant && dgnt_v) begin
      slot_full_d[dsel] = 1'b0;
      drr_d = (dsel == PTR_W'(N_REQ - 1)) ? '0 : dsel + 1'b1;
      if (stock_q[gitem] == '0) begin
        err_d[dsel] = 1'b1;
      end else begin
        stock_d[gitem] = stock_q[gitem] - 1'b1;
        start_d        = 1'b1;
        busy_d         = 1'b1;
        ditem_d        = gitem;
        owner_d        = dsel;
        dcnt_d         = DCNT_W'(DISP_CYCLES - 1);
        dst_d          = DSP_RUN;
      end
    end

    for (int r = 0; r < N_REQ; r++) begin
      if (item_rels[REL_W*r + ITEM_W]) begin
        if (slot_full_q[r]) begin
          err_d[r] = 1'b1;
        end else begin
          slot_full_d[r] = 1'b1;
          slot_item_d[r] = item_rels[REL_W*r +: ITEM_W];
        end
      end
    end

    if (restock) begin
      for (int i = 0; i < NUM_ITEMS; i++) stock_d[i] = STOCK_W'(STOCK_INIT);
    end

    for (int i = 0; i < NUM_ITEMS; i++) sold_d[i] = (stock_q[i] == '0);
  end

  always_comb begin
    hst_d  = hst_q;
    gcnt_d = gcnt_q;
    hrr_d  = hrr_q;
    coin_d = 1'b0;
    hdec   = '0;
    case (hst_q)
      HOP_IDLE: begin
        if (hgnt_v) begin
          hdec   = hgnt;
          coin_d = 1'b1;
          hrr_d  = (hsel == PTR_W'(N_REQ - 1)) ? '0 : hsel + 1'b1;
          hst_d  = HOP_EJECT;
        end
      end
      HOP_EJECT: begin
        gcnt_d = GCNT_W'(COIN_GAP - 1);
        hst_d  = HOP_GAP;
      end
      HOP_GAP: begin
        if (gcnt_q == '0) hst_d = HOP_IDLE;
        else              gcnt_d = gcnt_q - 1'b1;
      end
      default: hst_d = HOP_IDLE;
    endcase

    // A pulse and a serve in the same cycle cancel, so they never trip saturation.
    for (int r = 0; r < N_REQ; r++) begin
      owed_d[r] = owed_q[r];
      ovf[r]    = 1'b0;
      if (change_return[r] && !hdec[r]) begin
        if (&owed_q[r]) ovf[r]    = 1'b1;
        else            owed_d[r] = owed_q[r] + 1'b1;
      end else if (!change_return[r] && hdec[r]) begin
        owed_d[r] = owed_q[r] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_full_q <= '0;
      dst_q       <= DSP_IDLE;
      dcnt_q      <= '0;
      drr_q       <= '0;
      owner_q     <= '0;
      ditem_q     <= '0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      ack_q       <= '0;
      err_q       <= '0;
      sold_q      <= '0;
      hst_q       <= HOP_IDLE;
      gcnt_q      <= '0;
      hrr_q       <= '0;
      coin_q      <= 1'b0;
      for (int r = 0; r < N_REQ; r++) begin
        slot_item_q[r] <= '0;
        owed_q[r]      <= '0;
      end
      for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
    end else begin
      slot_full_q <= slot_full_d;
      slot_item_q <= slot_item_d;
      stock_q     <= stock_d;
      dst_q       <= dst_d;
      dcnt_q      <= dcnt_d;
      drr_q       <= drr_d;
      owner_q     <= owner_d;
      ditem_q     <= ditem_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      ack_q       <= ack_d;
      err_q       <= err_d | ovf;
      sold_q      <= sold_d;
      hst_q       <= hst_d;
      gcnt_q      <= gcnt_d;
      hrr_q       <= hrr_d;
      coin_q      <= coin_d;
      owed_q      <= owed_d;
    end
  end

  assign disp_start = start_q;
  assign disp_item  = ditem_q;
  assign disp_busy  = busy_q;
  assign coin_eject = coin_q;
  assign sold_out   = sold_q;
  assign rel_ack    = ack_q;
  assign err        = err_q;
endmodule
